load_store_unit: RTL

- Sequencer between the CPU memory stage and the word-organised data memory.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake.
- Drives the memory's mem_read/mem_write/address/write_data; loads sign- or zero-extend the result.
- Sub-word stores use read-modify-write, because the memory writes whole 32-bit words only.

---
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Sequencer between the CPU memory stage and a word-organised data
//            memory. Handles byte/halfword/word loads (sign/zero extended) and
//            stores; sub-word stores are done as read-modify-write because the
//            memory only writes whole 32-bit words.
// Revision : 1.0 - initial release
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word requests complete with resp_err = 1 and
//               no memory access.
//   undefined : no alignment check, resp_err stays 0, halfword lane is picked
//               by addr[1] only, word accesses ignore addr[1:0].
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we, req_size      1 = store; 00 byte, 01 half, 10/11 word
//   req_unsigned          loads: 1 = zero-extend, 0 = sign-extend
//   req_addr, req_wdata   byte address, right-justified store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  extended load data / misalignment flag (held)
//   mem_read, mem_write   memory strobes decoded from state
//   mem_address           word-aligned address
//   mem_write_data        full word to write
//   mem_read_data         combinational read data from memory
// ============================================================================
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;

  logic              misaligned;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

`ifdef LSU_MISALIGN_TRAP_EN
  // Reserved size 11 is a word access, hence req_size[1] covers both.
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Lane extraction for loads: shift the addressed lane down to bit 0.
  always_comb begin
    shifted   = mem_read_data;
    load_data = mem_read_data;
    case (size_q)
      2'b00: begin
        shifted   = mem_read_data >> {addr_q[1:0], 3'b000};
        load_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        shifted   = mem_read_data >> {addr_q[1], 4'b0000};
        load_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        shifted   = mem_read_data;
        load_data = mem_read_data;
      end
    endcase
  end

  // Old word with the target lane replaced by the store data.
  always_comb begin
    merged = mem_read_data;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (size_q == 2'b01) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misaligned)        state_nxt = RESP;
          else if (!req_we)      state_nxt = READ;
          else if (req_size[1])  state_nxt = WRITE;
          else                   state_nxt = READ;
        end
      end
      READ:    state_nxt = we_q ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      // Response registers only change on the way into RESP so they hold
      // their last value between responses.
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (misaligned) begin
              resp_rdata <= '0;
              resp_err   <= 1'b1;
            end
          end
        end
        READ: begin
          if (we_q) begin
            merge_q <= merged;
          end else begin
            resp_rdata <= load_data;
            resp_err   <= 1'b0;
          end
        end
        WRITE: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready      = (state == IDLE);
  assign mem_read       = (state == READ);
  assign mem_write      = (state == WRITE);
  assign resp_valid     = (state == RESP);
  assign mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_write_data = size_q[1] ? wdata_q : merge_q;

endmodule
`default_nettype wire
